// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and BCD digit helpers
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
   function automatic logic bcd_digit_ok(logic [3:0] d);
      return d <= BCD_MAX;
   endfunction
endpackage

// File: rtl/bcd_mul_by_5.sv
// bcd_mul_by_5: single BCD digit times five as a {tens, ones} digit pair
module bcd_mul_by_5 (
   input  logic [3:0] d_i,
   output logic [3:0] ones_o,
   output logic [3:0] tens_o
);
   // d*5 = 10*(d>>1) + 5*d[0]
   assign ones_o = d_i[0] ? 4'd5 : 4'd0;
   assign tens_o = {1'b0, d_i[3:1]};
endmodule

// File: rtl/bcd_serial_mul_by_5.sv
// bcd_serial_mul_by_5: digit-serial multi-digit BCD multiply-by-5 with valid/ready handshake
module bcd_serial_mul_by_5
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [4*DIGITS-1:0]     i_num_bcd,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [4*(DIGITS+1)-1:0] o_num_bcd,
   output logic                    o_err
);
   localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [3:0]                carry_q, carry_d;
   logic [4*DIGITS-1:0]       op_q, op_d;
   logic [4*(DIGITS+1)-1:0]   res_q, res_d;
   logic                      err_q, err_d;
   logic [3:0]                digit, ones, tens;
   logic                      last;
   assign digit = op_q[{cnt_q, 2'b00} +: 4];
   assign last  = cnt_q == CW'(DIGITS - 1);
   bcd_mul_by_5 u_mul (
      .d_i    (digit),
      .ones_o (ones),
      .tens_o (tens)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= '0;
         op_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         op_q    <= op_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = i_valid ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         DONE:    state_d = i_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // ones is 0 or 5 and carry at most 4, so each result digit needs no decimal adjust
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = carry_q;
      op_d    = op_q;
      res_d   = res_q;
      err_d   = err_q;
      if (state_q == IDLE && i_valid) begin
         op_d    = i_num_bcd;
         cnt_d   = '0;
         carry_d = '0;
         res_d   = '0;
         err_d   = 1'b0;
      end else if (state_q == RUN) begin
         res_d[{cnt_q, 2'b00} +: 4] = ones + carry_q;
         carry_d = tens;
         err_d   = err_q | ~bcd_digit_ok(digit);
         cnt_d   = cnt_q + 1'b1;
         if (last) res_d[4*DIGITS +: 4] = tens;
      end
   end
   always_comb begin
      o_ready   = state_q == IDLE && !i_rst;
      o_valid   = state_q == DONE;
      o_err     = o_valid && err_q;
      o_num_bcd = (o_valid && !err_q) ? res_q : '0;
   end
endmodule

// File: tb/tb_bcd_serial_mul_by_5.sv
// tb_bcd_serial_mul_by_5: directed table-driven checks plus handshake/reset corner sequences
module tb_bcd_serial_mul_by_5;
   localparam int DIGITS = 4;
   logic        clk = 0;
   logic        rst = 1;
   logic        i_valid = 0;
   logic        i_ready = 0;
   logic [15:0] i_num = '0;
   logic        o_ready, o_valid, o_err;
   logic [19:0] o_num;
   int          n_chk = 0;
   int          n_fail = 0;
   typedef struct {
      logic [15:0] op;
      logic [19:0] res;
      logic        err;
   } vec_t;
   vec_t vecs[6];
   always #5 clk = ~clk;
   bcd_serial_mul_by_5 #(.DIGITS(DIGITS)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_num_bcd (i_num),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_num_bcd (o_num),
      .o_err     (o_err)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic accept(input logic [15:0] op);
      int n = 0;
      while (!o_ready && n < 20) begin
         tick();
         n++;
      end
      chk("ready_before_accept", 32'(o_ready), 1);
      i_num = op;
      i_valid = 1;
      tick();
      i_valid = 0;
   endtask
   task automatic wait_valid(input string name);
      int n = 0;
      while (!o_valid && n < 20) begin
         chk({name, "_ready_low_run"}, 32'(o_ready), 0);
         tick();
         n++;
      end
      chk({name, "_latency"}, n, DIGITS);
   endtask
   task automatic run_vec(input vec_t v, input string name);
      accept(v.op);
      wait_valid(name);
      chk({name, "_res"}, 32'(o_num), 32'(v.res));
      chk({name, "_err"}, 32'(o_err), 32'(v.err));
      i_ready = 1;
      tick();
      i_ready = 0;
      chk({name, "_valid_drop"}, 32'(o_valid), 0);
      chk({name, "_ready_back"}, 32'(o_ready), 1);
   endtask
   initial begin
      logic [19:0] held;
      vecs[0] = '{16'h1234, 20'h06170, 1'b0};
      vecs[1] = '{16'h9999, 20'h49995, 1'b0};
      vecs[2] = '{16'h0000, 20'h00000, 1'b0};
      vecs[3] = '{16'h0001, 20'h00005, 1'b0};
      vecs[4] = '{16'h12A4, 20'h00000, 1'b1};
      vecs[5] = '{16'h0777, 20'h03885, 1'b0};
      tick();
      chk("rst_ready_low", 32'(o_ready), 0);
      tick();
      rst = 0;
      #1;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_num", 32'(o_num), 0);
      chk("rst_err", 32'(o_err), 0);
      chk("rst_ready", 32'(o_ready), 1);
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      // backpressure and ignored operands while busy
      accept(16'h0777);
      i_num = 16'h1111;
      i_valid = 1;
      wait_valid("bp");
      held = o_num;
      chk("bp_res", 32'(held), 32'h03885);
      for (int i = 0; i < 6; i++) begin
         i_valid = i[0];
         i_num = 16'h2222 + 16'(i);
         tick();
         chk("bp_valid_hold", 32'(o_valid), 1);
         chk("bp_num_hold", 32'(o_num), 32'(held));
         chk("bp_err_hold", 32'(o_err), 0);
         chk("bp_ready_low", 32'(o_ready), 0);
      end
      i_valid = 0;
      i_ready = 1;
      tick();
      i_ready = 0;
      chk("bp_release", 32'(o_valid), 0);
      // reset in the second RUN cycle discards the operation
      accept(16'h5555);
      tick();
      rst = 1;
      #1;
      chk("midrst_ready_low", 32'(o_ready), 0);
      tick();
      rst = 0;
      #1;
      chk("midrst_valid", 32'(o_valid), 0);
      chk("midrst_ready", 32'(o_ready), 1);
      chk("midrst_num", 32'(o_num), 0);
      repeat (DIGITS + 1) tick();
      chk("midrst_no_result", 32'(o_valid), 0);
      run_vec('{16'h0042, 20'h00210, 1'b0}, "post_rst");
      // back-to-back with consumer always ready
      i_ready = 1;
      accept(16'h0008);
      wait_valid("b2b0");
      chk("b2b0_res", 32'(o_num), 32'h00040);
      chk("b2b0_ready_done", 32'(o_ready), 0);
      i_num = 16'h0100;
      i_valid = 1;
      tick();
      chk("b2b_idle_ready", 32'(o_ready), 1);
      chk("b2b_idle_valid", 32'(o_valid), 0);
      tick();
      i_valid = 0;
      wait_valid("b2b1");
      chk("b2b1_res", 32'(o_num), 32'h00500);
      tick();
      i_ready = 0;
      chk("b2b1_done", 32'(o_valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
